// File: rtl/instr_seq_pkg.sv
// Shared types and default widths for the instruction sequencer slice.
// Holds the sequencer FSM state encoding.
package tproc_instr_pkg;

   localparam int unsigned DEF_INSTR_W = 64;
   localparam int unsigned DEF_ADDR_W  = 10;
   localparam int unsigned DEF_REP_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } seq_state_t;

endpackage

// File: rtl/instr_seq_if.sv
// Instruction stream towards the CLP array: valid/ready handshake.
// Carries the word plus the RAM address it was fetched from.
interface instr_seq_if import tproc_instr_pkg::*; #(
   parameter int unsigned INSTR_W = DEF_INSTR_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W
);
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr_data;
   logic [ADDR_W-1:0]  instr_addr;

   modport master (output instr_valid, output instr_data, output instr_addr, input instr_ready);
   modport slave  (input instr_valid, input instr_data, input instr_addr, output instr_ready);
endinterface

// File: rtl/instr_seq_ram.sv
// Simple dual-port instruction RAM: one write port, one registered read port.
// A read of the address being written returns the new word.
module instr_ram import tproc_instr_pkg::*; #(
   parameter int unsigned INSTR_W = DEF_INSTR_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [INSTR_W-1:0] rd_data
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [INSTR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
   end
endmodule

// File: rtl/instr_seq.sv
// Instruction buffer and sequencer: host loads a program into RAM, an
// acc_enable rising edge streams it (optionally repeated) to the CLP.
module instr_seq import tproc_instr_pkg::*; #(
   parameter int unsigned INSTR_W = DEF_INSTR_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned REP_W   = DEF_REP_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_en,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   output logic               load_err,
   input  logic [ADDR_W:0]    prog_len,
   input  logic [REP_W-1:0]   rep_cnt,
   input  logic               acc_enable,
   input  logic               acc_abort,
   instr_seq_if.master        instr,
   output logic               busy,
   output logic               done
);
   localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};

   typedef struct packed {
      logic [INSTR_W-1:0] data;
      logic [ADDR_W-1:0]  addr;
   } entry_t;

   seq_state_t         state, state_nxt;
   logic               acc_prev, start, abort, pop, pend, rd_issue, last_addr, last_read;
   logic [ADDR_W:0]    len_in, len_q, cur_len;
   logic [REP_W-1:0]   reps_in, reps_q, cur_reps, pass_cnt, cur_pass;
   logic [ADDR_W-1:0]  rd_addr, cur_addr, pend_addr;
   logic [1:0]         fifo_cnt;
   logic [2:0]         occ_nxt;
   entry_t             fifo0, fifo1, push_entry;
   logic [INSTR_W-1:0] ram_q;

   assign len_in   = prog_len[ADDR_W] ? DEPTH_LEN : prog_len;
   assign reps_in  = (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
   assign start    = (state == ST_IDLE) && acc_enable && !acc_prev;
   assign abort    = acc_abort && (state != ST_IDLE);
   assign pop      = instr.instr_valid && instr.instr_ready;

   // In IDLE the fetch pointers read as the fresh program start, so the
   // first read issues in the start cycle itself.
   assign cur_len  = (state == ST_IDLE) ? len_in  : len_q;
   assign cur_reps = (state == ST_IDLE) ? reps_in : reps_q;
   assign cur_addr = (state == ST_IDLE) ? '0 : rd_addr;
   assign cur_pass = (state == ST_IDLE) ? '0 : pass_cnt;

   // Occupancy after this cycle's push/pop plus the new read must fit in 2.
   assign occ_nxt   = 3'(fifo_cnt) + 3'(pend) - 3'(pop);
   assign rd_issue  = !abort && (occ_nxt < 3'd2) &&
                      ((state == ST_RUN) || (start && (len_in != '0)));
   assign last_addr = ({1'b0, cur_addr} == (cur_len - (ADDR_W+1)'(1)));
   assign last_read = rd_issue && last_addr && (cur_pass == (cur_reps - REP_W'(1)));

   instr_ram #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .wr_en   (load_en && (state == ST_IDLE)),
      .wr_addr (load_addr),
      .wr_data (load_data),
      .rd_en   (rd_issue),
      .rd_addr (cur_addr),
      .rd_data (ram_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = (len_in == '0) ? ST_DONE : (last_read ? ST_DRAIN : ST_RUN);
         ST_RUN:   if (last_read) state_nxt = ST_DRAIN;
         ST_DRAIN: if (pop && (fifo_cnt == 2'd1) && !pend) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (abort) state_nxt = ST_IDLE;
   end

   always_comb begin
      busy = (state != ST_IDLE);
      done = (state == ST_DONE);
   end

   assign instr.instr_valid = (fifo_cnt != 2'd0);
   assign instr.instr_data  = fifo0.data;
   assign instr.instr_addr  = fifo0.addr;
   assign push_entry        = '{data: ram_q, addr: pend_addr};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_prev  <= 1'b0;
         load_err  <= 1'b0;
         len_q     <= '0;
         reps_q    <= '0;
         rd_addr   <= '0;
         pass_cnt  <= '0;
         pend      <= 1'b0;
         pend_addr <= '0;
         fifo_cnt  <= '0;
         fifo0     <= '0;
         fifo1     <= '0;
      end else begin
         acc_prev  <= acc_enable;
         load_err  <= load_en && (state != ST_IDLE);
         if (start) begin
            len_q  <= len_in;
            reps_q <= reps_in;
         end
         if (rd_issue) begin
            if (last_addr) begin
               rd_addr  <= '0;
               pass_cnt <= cur_pass + REP_W'(1);
            end else begin
               rd_addr  <= cur_addr + ADDR_W'(1);
               pass_cnt <= cur_pass;
            end
         end
         pend      <= rd_issue;
         pend_addr <= cur_addr;
         // Abort drops queued words and any read still in flight.
         if (abort) begin
            fifo_cnt <= '0;
         end else begin
            case ({pend, pop})
               2'b10: begin
                  if (fifo_cnt == 2'd0) fifo0 <= push_entry;
                  else                  fifo1 <= push_entry;
                  fifo_cnt <= fifo_cnt + 2'd1;
               end
               2'b01: begin
                  fifo0    <= fifo1;
                  fifo_cnt <= fifo_cnt - 2'd1;
               end
               2'b11: begin
                  if (fifo_cnt == 2'd2) begin
                     fifo0 <= fifo1;
                     fifo1 <= push_entry;
                  end else begin
                     fifo0 <= push_entry;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_instr_seq.sv
// Scoreboard bench for instr_seq: directed runs push expected words,
// a negedge monitor pops and compares on every handshake.
module tb_instr_seq;
   localparam int unsigned IW = 64;
   localparam int unsigned AW = 10;
   localparam int unsigned RW = 8;

   typedef struct packed {
      logic [IW-1:0] data;
      logic [AW-1:0] addr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [IW-1:0] load_data = '0;
   logic          load_err;
   logic [AW:0]   prog_len = '0;
   logic [RW-1:0] rep_cnt = '0;
   logic          acc_enable = 1'b0;
   logic          acc_abort = 1'b0;
   logic          busy, done;

   instr_seq_if #(.INSTR_W(IW), .ADDR_W(AW)) bus ();

   instr_seq #(.INSTR_W(IW), .ADDR_W(AW), .REP_W(RW)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .load_err   (load_err),
      .prog_len   (prog_len),
      .rep_cnt    (rep_cnt),
      .acc_enable (acc_enable),
      .acc_abort  (acc_abort),
      .instr      (bus),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   exp_t        sb[$];
   exp_t        held;
   logic        stall = 1'b0;
   int unsigned n_checks = 0, n_fail = 0;
   int unsigned done_cnt = 0, xfer_cnt = 0, done_base = 0, xfer_base = 0;
   int unsigned ready_mode = 0;

   function automatic logic [IW-1:0] word(input int unsigned i);
      return 64'hC0DE_0000_0000_00A0 + 64'(i);
   endfunction

   task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input int unsigned a, input logic [IW-1:0] d);
      load_en = 1'b1;
      load_addr = AW'(a);
      load_data = d;
      tick();
      load_en = 1'b0;
   endtask

   task automatic push_prog(input int unsigned len, input int unsigned rep);
      int unsigned r;
      r = (rep == 0) ? 1 : rep;
      for (int unsigned p = 0; p < r; p++)
         for (int unsigned i = 0; i < len; i++)
            sb.push_back('{data: word(i), addr: AW'(i)});
   endtask

   // Leaves the bench one cycle after the start edge was sampled.
   task automatic start_run(input int unsigned len, input int unsigned rep);
      prog_len = (AW+1)'(len);
      rep_cnt = RW'(rep);
      done_base = done_cnt;
      xfer_base = xfer_cnt;
      acc_enable = 1'b1;
      tick();
      acc_enable = 1'b0;
   endtask

   task automatic finish_run(input int unsigned exp_xfers);
      int unsigned k;
      k = 0;
      while (busy && k < 400) begin
         tick();
         k++;
      end
      chk("run_ends_busy", busy, 0);
      tick();
      chk("run_done_pulses", done_cnt - done_base, 1);
      chk("run_xfers", xfer_cnt - xfer_base, exp_xfers);
      chk("run_sb_empty", sb.size(), 0);
   endtask

   initial begin
      int unsigned ph;
      ph = 0;
      bus.instr_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: bus.instr_ready = 1'b0;
            1: bus.instr_ready = 1'b1;
            default: begin
               bus.instr_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
               ph++;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (stall && bus.instr_valid) begin
         chk("stall_data", bus.instr_data, held.data);
         chk("stall_addr", 64'(bus.instr_addr), 64'(held.addr));
      end
      stall = bus.instr_valid && !bus.instr_ready;
      held = '{data: bus.instr_data, addr: bus.instr_addr};
      if (bus.instr_valid && bus.instr_ready) begin
         xfer_cnt++;
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_xfer: got addr %0d data %0h expected no transfer",
                     bus.instr_addr, bus.instr_data);
         end else begin
            e = sb.pop_front();
            chk("xfer_data", bus.instr_data, e.data);
            chk("xfer_addr", 64'(bus.instr_addr), 64'(e.addr));
         end
      end
      if (done) done_cnt++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned bad;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", bus.instr_valid, 0);
      chk("rst_load_err", load_err, 0);
      chk("rst_data", bus.instr_data, 0);
      chk("rst_addr", 64'(bus.instr_addr), 0);
      rst = 1'b1;
      tick();
      for (int unsigned i = 0; i < 4; i++) load_word(i, word(i));

      // Basic run with cycle-exact trace of valid/done/busy.
      ready_mode = 1;
      tick();
      push_prog(4, 1);
      start_run(4, 1);
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) tick();
         chk($sformatf("t1_valid_c%0d", k), bus.instr_valid, (k >= 2 && k <= 5));
         chk($sformatf("t1_done_c%0d", k), done, (k == 6));
         chk($sformatf("t1_busy_c%0d", k), busy, (k >= 1 && k <= 6));
      end
      chk("t1_done_pulses", done_cnt - done_base, 1);
      chk("t1_xfers", xfer_cnt - xfer_base, 4);
      chk("t1_sb_empty", sb.size(), 0);

      // Repeat with back-pressure.
      ready_mode = 2;
      tick();
      push_prog(3, 2);
      start_run(3, 2);
      finish_run(6);

      // Abort with two words queued, then a clean restart.
      ready_mode = 0;
      tick();
      start_run(4, 1);
      tick();
      tick();
      chk("t3_valid_before_abort", bus.instr_valid, 1);
      acc_abort = 1'b1;
      tick();
      acc_abort = 1'b0;
      chk("t3_valid_after_abort", bus.instr_valid, 0);
      chk("t3_busy_after_abort", busy, 0);
      for (int unsigned i = 0; i < 5; i++) tick();
      chk("t3_no_done", done_cnt - done_base, 0);
      chk("t3_no_xfer", xfer_cnt - xfer_base, 0);
      ready_mode = 1;
      tick();
      push_prog(4, 1);
      start_run(4, 1);
      finish_run(4);

      // Load while running is rejected.
      push_prog(4, 1);
      start_run(4, 1);
      load_en = 1'b1;
      load_addr = AW'(1);
      load_data = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      load_en = 1'b0;
      chk("t4_load_err_pulse", load_err, 1);
      tick();
      chk("t4_load_err_clear", load_err, 0);
      finish_run(4);
      push_prog(4, 1);
      start_run(4, 1);
      finish_run(4);

      // Empty program, acc_enable held high afterwards.
      prog_len = '0;
      rep_cnt = RW'(1);
      done_base = done_cnt;
      xfer_base = xfer_cnt;
      acc_enable = 1'b1;
      tick();
      chk("t5_done", done, 1);
      chk("t5_valid", bus.instr_valid, 0);
      tick();
      chk("t5_done_clear", done, 0);
      chk("t5_busy_clear", busy, 0);
      prog_len = (AW+1)'(4);
      bad = 0;
      for (int unsigned i = 0; i < 20; i++) begin
         tick();
         if (busy) bad++;
      end
      acc_enable = 1'b0;
      chk("t5_no_restart", bad, 0);
      chk("t5_done_pulses", done_cnt - done_base, 1);
      chk("t5_no_xfer", xfer_cnt - xfer_base, 0);

      // Asynchronous reset in the middle of a run.
      push_prog(4, 3);
      start_run(4, 3);
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      chk("t6_valid", bus.instr_valid, 0);
      chk("t6_data", bus.instr_data, 0);
      chk("t6_addr", 64'(bus.instr_addr), 0);
      chk("t6_load_err", load_err, 0);
      sb.delete();
      tick();
      tick();
      rst = 1'b1;
      bad = 0;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         if (busy || bus.instr_valid) bad++;
      end
      chk("t6_idle_after_release", bad, 0);
      push_prog(2, 1);
      start_run(2, 1);
      finish_run(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
